// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative radix-2 multiply/divide engine producing HI/LO
//
// One radix-2 step per clock. A start edge (E0) latches the operands; the
// edge completing step SIZE (E(SIZE)) loads hiOut/loOut and pulses done.
//
// Optional feature macro: MULDIV_SIGNED_EN
//   defined   : signedOp port exists; signedOp=1 selects two's-complement ops
//   undefined : no signedOp port, all operations unsigned
//
// Ports:
//   clk       rising-edge clock
//   rst       asynchronous, active-high reset
//   start     request a new op (ignored while busy)
//   op        0 = multiply, 1 = divide
//   signedOp  0 = unsigned, 1 = signed (MULDIV_SIGNED_EN only)
//   operandA  multiplicand / dividend
//   operandB  multiplier / divisor
//   busy      high while iterating
//   done      one-cycle pulse, results valid
//   hiOut     multiply: upper product half; divide: remainder
//   loOut     multiply: lower product half; divide: quotient
//   divByZero high with done when a divide had operandB == 0

module mult_div_unit #(
  parameter int SIZE = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            op,
`ifdef MULDIV_SIGNED_EN
  input  logic            signedOp,
`endif
  input  logic [SIZE-1:0] operandA,
  input  logic [SIZE-1:0] operandB,
  output logic            busy,
  output logic            done,
  output logic [SIZE-1:0] hiOut,
  output logic [SIZE-1:0] loOut,
  output logic            divByZero
);

  localparam int CW = $clog2(SIZE + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   count;
  logic            op_r;
  logic            dz_r;       // divide with a zero divisor
  logic            res_neg_r;  // negate product (mul) or quotient (div)
  logic            rem_neg_r;  // negate remainder (div only)
  logic [SIZE-1:0] m_r;        // multiplicand (mul) or divisor (div)
  logic [SIZE-1:0] acc_hi;     // product high half (mul) or partial remainder (div)
  logic [SIZE-1:0] acc_lo;     // multiplier/product low (mul) or dividend/quotient (div)

  // Signed-mode request, tied low when the feature is compiled out
  logic sgn;
`ifdef MULDIV_SIGNED_EN
  assign sgn = signedOp;
`else
  assign sgn = 1'b0;
`endif

  // Operand magnitudes taken at E0; the most negative value maps onto its
  // own bit pattern, which is the correct unsigned magnitude.
  logic            a_neg, b_neg;
  logic [SIZE-1:0] a_mag, b_mag;

  always_comb begin
    a_neg = sgn & operandA[SIZE-1];
    b_neg = sgn & operandB[SIZE-1];
    a_mag = a_neg ? (~operandA + SIZE'(1)) : operandA;
    b_mag = b_neg ? (~operandB + SIZE'(1)) : operandB;
  end

  // One iteration step of the shared datapath
  logic [SIZE:0]   mul_sum;
  logic [SIZE:0]   div_shift;
  logic [SIZE:0]   div_trial;
  logic            div_ok;
  logic [SIZE-1:0] step_hi, step_lo;

  always_comb begin
    // Shift-add: add multiplicand when the current multiplier LSB is set,
    // then shift {carry, hi, lo} right by one.
    mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, m_r} : {(SIZE+1){1'b0}});
    // Restoring: shift the next dividend bit into the remainder, try to
    // subtract; the borrow bit decides the quotient bit. A zero divisor
    // always succeeds, giving an all-ones quotient and remainder == dividend.
    div_shift = {acc_hi, acc_lo[SIZE-1]};
    div_trial = div_shift - {1'b0, m_r};
    div_ok    = ~div_trial[SIZE];
    if (!op_r) begin
      step_hi = mul_sum[SIZE:1];
      step_lo = {mul_sum[0], acc_lo[SIZE-1:1]};
    end else begin
      step_hi = div_ok ? div_trial[SIZE-1:0] : div_shift[SIZE-1:0];
      step_lo = {acc_lo[SIZE-2:0], div_ok};
    end
  end

  // Sign correction applied to the final step's result
  logic [2*SIZE-1:0] prod_fix;
  logic [SIZE-1:0]   res_hi, res_lo;

  always_comb begin
    prod_fix = res_neg_r ? (~{step_hi, step_lo} + (2*SIZE)'(1)) : {step_hi, step_lo};
    if (!op_r) begin
      res_hi = prod_fix[2*SIZE-1:SIZE];
      res_lo = prod_fix[SIZE-1:0];
    end else begin
      res_hi = rem_neg_r ? (~step_hi + SIZE'(1)) : step_hi;
      res_lo = res_neg_r ? (~step_lo + SIZE'(1)) : step_lo;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      count     <= '0;
      op_r      <= 1'b0;
      dz_r      <= 1'b0;
      res_neg_r <= 1'b0;
      rem_neg_r <= 1'b0;
      m_r       <= '0;
      acc_hi    <= '0;
      acc_lo    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      divByZero <= 1'b0;
      hiOut     <= '0;
      loOut     <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done      <= 1'b0;
          divByZero <= 1'b0;
          if (start) begin
            op_r   <= op;
            dz_r   <= op & (operandB == '0);
            m_r    <= op ? b_mag : a_mag;
            acc_hi <= '0;
            acc_lo <= op ? a_mag : b_mag;
            // Divide by zero keeps the raw all-ones quotient; the remainder
            // correction restores the original dividend bits.
            res_neg_r <= (a_neg ^ b_neg) & ~(op & (operandB == '0));
            rem_neg_r <= op & a_neg;
            count  <= '0;
            busy   <= 1'b1;
            state  <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + CW'(1);
          if (count == CW'(SIZE - 1)) begin
            hiOut     <= res_hi;
            loOut     <= res_lo;
            done      <= 1'b1;
            divByZero <= dz_r;
            busy      <= 1'b0;
            state     <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - directed self-checking bench for mult_div_unit

module tb_mult_div_unit;

  localparam int SIZE = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            op;
  logic            signed_i;
  logic [SIZE-1:0] operandA;
  logic [SIZE-1:0] operandB;
  logic            busy;
  logic            done;
  logic [SIZE-1:0] hiOut;
  logic [SIZE-1:0] loOut;
  logic            divByZero;

  int tests = 0;
  int fails = 0;

  mult_div_unit #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
`ifdef MULDIV_SIGNED_EN
    .signedOp  (signed_i),
`endif
    .operandA  (operandA),
    .operandB  (operandB),
    .busy      (busy),
    .done      (done),
    .hiOut     (hiOut),
    .loOut     (loOut),
    .divByZero (divByZero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Launch an op at the next edge (E0), run to E(SIZE) and check the exact
  // busy/done timing and the results. Returns just after E(SIZE), inside the
  // DONE cycle. With mid=1 a start pulse with other operands hits RUN edge 10.
  task automatic do_op(input string tag, input logic o, input logic [SIZE-1:0] a,
                       input logic [SIZE-1:0] b, input logic mid,
                       input logic [SIZE-1:0] exp_hi, input logic [SIZE-1:0] exp_lo,
                       input logic exp_dz);
    @(negedge clk);
    start = 1'b1; op = o; operandA = a; operandB = b;
    @(posedge clk); #1;
    chk({tag, "_e0_busy_done"}, {62'd0, busy, done}, 64'd2);
    for (int i = 1; i <= SIZE; i++) begin
      @(negedge clk);
      start = mid && (i == 10);
      if (i == 1 || (mid && i == 10)) begin
        operandA = $urandom; operandB = $urandom; op = ~o;
      end
      @(posedge clk); #1;
      if (i < SIZE)
        chk({tag, "_run_busy_done"}, {62'd0, busy, done}, 64'd2);
    end
    chk({tag, "_end_busy_done"}, {62'd0, busy, done}, 64'd1);
    chk({tag, "_hi"}, {32'd0, hiOut}, {32'd0, exp_hi});
    chk({tag, "_lo"}, {32'd0, loOut}, {32'd0, exp_lo});
    chk({tag, "_dz"}, {63'd0, divByZero}, {63'd0, exp_dz});
  endtask

  // Let the DONE cycle lapse with start low; done/divByZero drop, results hold
  task automatic idle_after(input string tag, input logic [SIZE-1:0] exp_hi,
                            input logic [SIZE-1:0] exp_lo);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk({tag, "_post_flags"}, {61'd0, busy, done, divByZero}, 64'd0);
    chk({tag, "_post_hold"}, {hiOut, loOut}, {exp_hi, exp_lo});
  endtask

  initial begin
    logic seen_done;
    rst = 1'b1; start = 1'b0; op = 1'b0; signed_i = 1'b0;
    operandA = '0; operandB = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {61'd0, busy, done, divByZero}, 64'd0);
    chk("reset_hilo", {hiOut, loOut}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: unsigned multiply 7 x 6
    do_op("mul7x6", 1'b0, 32'd7, 32'd6, 1'b0, 32'h0, 32'h2A, 1'b0);
    idle_after("mul7x6", 32'h0, 32'h2A);

    // 2: unsigned multiply of all-ones operands
    do_op("mulmax", 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 32'h1, 1'b0);
    idle_after("mulmax", 32'hFFFFFFFE, 32'h1);

    // 3: divide 100/7, then back-to-back 9/3 accepted in the DONE cycle
    do_op("div100_7", 1'b1, 32'd100, 32'd7, 1'b0, 32'd2, 32'd14, 1'b0);
    do_op("div9_3", 1'b1, 32'd9, 32'd3, 1'b0, 32'd0, 32'd3, 1'b0);
    idle_after("div9_3", 32'd0, 32'd3);

    // 4: divide by zero
    do_op("div5_0", 1'b1, 32'd5, 32'd0, 1'b0, 32'd5, 32'hFFFFFFFF, 1'b1);
    idle_after("div5_0", 32'd5, 32'hFFFFFFFF);

    // 5: mid-RUN start ignored
    do_op("mul3x4", 1'b0, 32'd3, 32'd4, 1'b1, 32'd0, 32'd12, 1'b0);
    idle_after("mul3x4", 32'd0, 32'd12);

    // 5b: reset mid-RUN clears outputs with no clock edge, no done afterwards
    @(negedge clk);
    start = 1'b1; op = 1'b0; operandA = 32'd1234; operandB = 32'd5678;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_flags", {61'd0, busy, done, divByZero}, 64'd0);
    chk("rst_mid_hilo", {hiOut, loOut}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      seen_done = seen_done | done | busy;
    end
    chk("rst_mid_no_done", {63'd0, seen_done}, 64'd0);

`ifdef MULDIV_SIGNED_EN
    // 6: signed operations
    signed_i = 1'b1;
    do_op("smul_m7x3", 1'b0, 32'hFFFFFFF9, 32'd3, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    do_op("sdiv_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    do_op("sdiv_m7_0", 1'b1, 32'hFFFFFFF9, 32'd0, 1'b0, 32'hFFFFFFF9, 32'hFFFFFFFF, 1'b1);
    idle_after("sdiv_m7_0", 32'hFFFFFFF9, 32'hFFFFFFFF);
    signed_i = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
